register_bank: RTL and testbench

//   32 x 32-bit general-purpose register file of the multicycle MIPS datapath.

---
 rtl/register_bank_pkg.sv | 33 +++
 rtl/register_bank_read_port.sv | 31 +++
 rtl/register_bank.sv | 93 +++++++++
 tb/tb_register_bank.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
//------------------------------------------------------------------------------
// Module      : register_bank_pkg
// Description : Shared sizes, architectural register indices and
//               destination-mux selection codes for the MIPS register bank.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package register_bank_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int WIDX_W   = 6;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;
    localparam int SP_RESET = 227;

    // Selection codes driven into the write-destination mux by control.
    typedef enum logic [1:0] {
        DST_RT  = 2'd0,
        DST_RD  = 2'd1,
        DST_RA  = 2'd2,
        DST_BAD = 2'd3
    } dst_sel_e;

    // Index the mux emits for DST_BAD; deliberately outside the register range.
    localparam logic [WIDX_W-1:0] DST_BAD_IDX = 6'd63;

endpackage : register_bank_pkg

`default_nettype wire

// File: rtl/register_bank_read_port.sv
//------------------------------------------------------------------------------
// Module      : register_bank_read_port
// Description : Combinational read port; index 0 is forced to zero.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_bank_read_port #(
    parameter int DATA_W   = register_bank_pkg::DATA_W,
    parameter int NUM_REGS = register_bank_pkg::NUM_REGS
) (
    input  logic [DATA_W-1:0]           regs [NUM_REGS],
    input  logic [$clog2(NUM_REGS)-1:0] idx,
    output logic [DATA_W-1:0]           data
);

    import register_bank_pkg::*;

    localparam int                    c_idx_w    = $clog2(NUM_REGS);
    localparam logic [c_idx_w-1:0]    c_zero_idx = c_idx_w'(REG_ZERO);

    always_comb begin
        data = '0;
        if (idx != c_zero_idx) begin
            data = regs[idx];
        end
    end

endmodule : register_bank_read_port

`default_nettype wire

// File: rtl/register_bank.sv
//------------------------------------------------------------------------------
// Module      : register_bank
// Description : 32 x 32 MIPS register file, two read ports, one write port,
//               $sp preset on reset and a sticky illegal-destination flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_bank #(
    parameter int DATA_W   = register_bank_pkg::DATA_W,
    parameter int NUM_REGS = register_bank_pkg::NUM_REGS,
    parameter int WIDX_W   = register_bank_pkg::WIDX_W,
    parameter int SP_INDEX = register_bank_pkg::REG_SP,
    parameter int SP_RESET = register_bank_pkg::SP_RESET
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        RegWrite,
    input  logic [$clog2(NUM_REGS)-1:0] ReadReg1,
    input  logic [$clog2(NUM_REGS)-1:0] ReadReg2,
    input  logic [WIDX_W-1:0]           WriteReg,
    input  logic [DATA_W-1:0]           WriteData,
    input  logic                        err_clr,
    output logic [DATA_W-1:0]           ReadData1,
    output logic [DATA_W-1:0]           ReadData2,
    output logic                        idx_err
);

    import register_bank_pkg::*;

    localparam int                  c_ridx_w   = $clog2(NUM_REGS);
    localparam logic [WIDX_W-1:0]   c_num_regs = WIDX_W'(NUM_REGS);
    localparam logic [WIDX_W-1:0]   c_zero_idx = WIDX_W'(REG_ZERO);
    localparam logic [DATA_W-1:0]   c_sp_reset = DATA_W'(SP_RESET);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_idx_err;

    logic                w_idx_legal;
    logic                w_wr_en;
    logic                w_err_set;
    logic [c_ridx_w-1:0] w_wr_idx;

    // The extra WriteReg bit exists only so that illegal destinations are visible.
    assign w_idx_legal = (WriteReg < c_num_regs);
    assign w_wr_en     = RegWrite && w_idx_legal && (WriteReg != c_zero_idx);
    assign w_err_set   = RegWrite && !w_idx_legal;
    assign w_wr_idx    = WriteReg[c_ridx_w-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == SP_INDEX) ? c_sp_reset : '0;
            end
        end else if (w_wr_en) begin
            r_regs[w_wr_idx] <= WriteData;
        end
    end

    // A new error takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx_err <= 1'b0;
        end else if (w_err_set) begin
            r_idx_err <= 1'b1;
        end else if (err_clr) begin
            r_idx_err <= 1'b0;
        end
    end

    assign idx_err = r_idx_err;

    register_bank_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_read_port1 (
        .regs (r_regs),
        .idx  (ReadReg1),
        .data (ReadData1)
    );

    register_bank_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_read_port2 (
        .regs (r_regs),
        .idx  (ReadReg2),
        .data (ReadData2)
    );

endmodule : register_bank

`default_nettype wire

// File: tb/tb_register_bank.sv
//------------------------------------------------------------------------------
// Module      : tb_register_bank
// Description : Self-checking bench for register_bank with a reference model
//               and an expected-value scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [5:0]  WriteReg;
    logic [31:0] WriteData;
    logic        err_clr;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        idx_err;

    always #5 clk = ~clk;

    register_bank u_dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .err_clr   (err_clr),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .idx_err   (idx_err)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] mdl [32];
    logic        merr;
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mdl[29] = 32'd227;
        merr    = 1'b0;
    endtask

    // Drive both read ports between edges and compare data plus error flag.
    task automatic read_pair(input logic [4:0] a, input logic [4:0] b, input string tag);
        @(negedge clk);
        ReadReg1 = a;
        ReadReg2 = b;
        sb_push({tag, "_rd1"}, mdl[a]);
        sb_push({tag, "_rd2"}, mdl[b]);
        sb_push({tag, "_err"}, {31'd0, merr});
        #1;
        sb_check(ReadData1);
        sb_check(ReadData2);
        sb_check({31'd0, idx_err});
    endtask

    task automatic do_cycle(input logic we, input logic [5:0] widx,
                            input logic [31:0] wd, input logic clr);
        @(negedge clk);
        RegWrite  = we;
        WriteReg  = widx;
        WriteData = wd;
        err_clr   = clr;
        @(posedge clk);
        if (we && widx != 6'd0 && widx < 6'd32) mdl[widx[4:0]] = wd;
        if (we && widx >= 6'd32) merr = 1'b1;
        else if (clr)            merr = 1'b0;
        #1;
        RegWrite = 1'b0;
        err_clr  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        RegWrite  = 1'b0;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;
        WriteReg  = 6'd0;
        WriteData = 32'd0;
        err_clr   = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        read_pair(5'd0, 5'd29, "por");
        @(negedge clk);
        reset = 1'b1;

        // Load every register so that a later reset has something to clear.
        for (int i = 1; i < 32; i++) do_cycle(1'b1, 6'(i), $urandom, 1'b0);
        read_pair(5'd5, 5'd29, "fill");
        do_cycle(1'b1, 6'd32, 32'd5, 1'b0);
        read_pair(5'd1, 5'd2, "pre_rst_err");

        // Asynchronous reset asserted mid-cycle, checked before any clock edge.
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        ReadReg1 = 5'd29;
        ReadReg2 = 5'd5;
        sb_push("async_rst_sp", mdl[29]);
        sb_push("async_rst_r5", mdl[5]);
        sb_push("async_rst_err", {31'd0, merr});
        #1;
        sb_check(ReadData1);
        sb_check(ReadData2);
        sb_check({31'd0, idx_err});
        for (int i = 0; i < 32; i += 2) read_pair(5'(i), 5'(i + 1), "rst");
        @(negedge clk);
        reset = 1'b1;

        // No forwarding: old value in the write cycle, new value after the edge.
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 6'd8;
        WriteData = 32'hDEADBEEF;
        ReadReg1  = 5'd8;
        ReadReg2  = 5'd0;
        sb_push("wr8_same_cycle", mdl[8]);
        #1;
        sb_check(ReadData1);
        @(posedge clk);
        mdl[8] = 32'hDEADBEEF;
        #1;
        RegWrite = 1'b0;
        sb_push("wr8_after_edge", mdl[8]);
        #1;
        sb_check(ReadData1);

        do_cycle(1'b1, 6'd0, 32'hFFFFFFFF, 1'b0);
        read_pair(5'd0, 5'd8, "zero_guard");

        do_cycle(1'b1, 6'd32, 32'd5, 1'b0);
        for (int i = 0; i < 32; i += 2) read_pair(5'(i), 5'(i + 1), "oor");
        do_cycle(1'b0, 6'd0, 32'd0, 1'b1);
        read_pair(5'd8, 5'd0, "err_clr");
        do_cycle(1'b1, 6'd40, 32'd7, 1'b1);
        read_pair(5'd8, 5'd0, "set_wins");
        do_cycle(1'b0, 6'd0, 32'd0, 1'b1);
        do_cycle(1'b0, 6'd33, 32'd9, 1'b0);
        read_pair(5'd1, 5'd8, "we_low");

        do_cycle(1'b1, 6'd31, 32'h40, 1'b0);
        do_cycle(1'b1, 6'd29, 32'h100, 1'b0);
        read_pair(5'd31, 5'd29, "ra_sp");

        repeat (60) begin
            do_cycle(1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 40)),
                     $urandom, 1'($urandom_range(0, 4) == 0));
            read_pair(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rnd");
        end

        // Reset coincident with a write to reg 5: reset must win.
        do_cycle(1'b1, 6'd5, 32'h12345678, 1'b0);
        read_pair(5'd5, 5'd29, "pre_rst_wr");
        @(negedge clk);
        RegWrite  = 1'b1;
        WriteReg  = 6'd5;
        WriteData = 32'hAAAA5555;
        #3;
        reset = 1'b0;
        @(posedge clk);
        #2;
        RegWrite = 1'b0;
        model_reset();
        read_pair(5'd5, 5'd29, "rst_wr");
        @(negedge clk);
        reset = 1'b1;
        read_pair(5'd5, 5'd0, "post_rst");

        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_bank

`default_nettype wire
